// File: rtl/btn_updown_counter.sv
// Two-button up/down modulo counter: each raw button is synchronised, debounced
// and edge-detected, and the resulting one-cycle events step a wrap/saturate counter.
module btn_updown_counter #(
    parameter int MOD       = 4,
    parameter int WIDTH     = 2,
    parameter int DB_CYCLES = 16,
    parameter int SATURATE  = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             btn_up,
    input  logic             btn_dn,
    input  logic             clr,
    output logic [WIDTH-1:0] count,
    output logic             up_pulse,
    output logic             dn_pulse,
    output logic             wrap_pulse,
    output logic             at_max,
    output logic             at_min
);

    localparam int CW = $clog2(DB_CYCLES + 1);
    localparam logic [CW-1:0]    DB_LAST   = CW'(DB_CYCLES - 1);
    localparam logic [CW-1:0]    CNT_ONE   = CW'(1);
    localparam logic [WIDTH-1:0] COUNT_MAX = WIDTH'(MOD - 1);
    localparam logic [WIDTH-1:0] COUNT_ONE = WIDTH'(1);

    generate
        if ((2 ** WIDTH) < MOD || MOD < 2 || DB_CYCLES < 1) begin : g_bad_params
            $error("btn_updown_counter: illegal parameter combination");
        end
    endgenerate

    // Bit 0 carries the up button, bit 1 the down button.
    logic [1:0]    raw_s;
    logic [1:0]    sync1_r;
    logic [1:0]    sync2_r;
    logic [1:0]    stable_r;
    logic [1:0]    stable_d_r;
    logic [1:0]    rise_s;
    logic [CW-1:0] db_cnt_r [2];

    logic [WIDTH-1:0] count_r;
    logic [WIDTH-1:0] next_count_s;
    logic             next_wrap_s;
    logic             up_pulse_r;
    logic             dn_pulse_r;
    logic             wrap_pulse_r;
    logic             at_max_r;
    logic             at_min_r;

    assign raw_s  = {btn_dn, btn_up};
    assign rise_s = stable_r & ~stable_d_r;

    // Two-stage synchroniser for both raw buttons.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_r <= 2'b00;
            sync2_r <= 2'b00;
        end else begin
            sync1_r <= raw_s;
            sync2_r <= sync1_r;
        end
    end

    // Debounce: a new level is accepted only after DB_CYCLES consecutive differing samples.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stable_r <= 2'b00;
            for (int i = 0; i < 2; i++) begin
                db_cnt_r[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (sync2_r[i] == stable_r[i]) begin
                    db_cnt_r[i] <= '0;
                end else if (db_cnt_r[i] == DB_LAST) begin
                    stable_r[i] <= sync2_r[i];
                    db_cnt_r[i] <= '0;
                end else begin
                    db_cnt_r[i] <= db_cnt_r[i] + CNT_ONE;
                end
            end
        end
    end

    // Next-count selection; clear beats everything and coincident up/down cancel.
    always_comb begin
        next_count_s = count_r;
        next_wrap_s  = 1'b0;
        if (clr) begin
            next_count_s = '0;
        end else if (rise_s[0] && rise_s[1]) begin
            next_count_s = count_r;
        end else if (rise_s[0]) begin
            if (count_r != COUNT_MAX) begin
                next_count_s = count_r + COUNT_ONE;
            end else if (SATURATE != 0) begin
                next_count_s = count_r;
            end else begin
                next_count_s = '0;
                next_wrap_s  = 1'b1;
            end
        end else if (rise_s[1]) begin
            if (count_r != '0) begin
                next_count_s = count_r - COUNT_ONE;
            end else if (SATURATE != 0) begin
                next_count_s = count_r;
            end else begin
                next_count_s = COUNT_MAX;
                next_wrap_s  = 1'b1;
            end
        end else begin
            next_count_s = count_r;
        end
    end

    // Registered count, event strobes and range flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stable_d_r   <= 2'b00;
            count_r      <= '0;
            up_pulse_r   <= 1'b0;
            dn_pulse_r   <= 1'b0;
            wrap_pulse_r <= 1'b0;
            at_max_r     <= 1'b0;
            at_min_r     <= 1'b1;
        end else begin
            stable_d_r   <= stable_r;
            count_r      <= next_count_s;
            up_pulse_r   <= rise_s[0];
            dn_pulse_r   <= rise_s[1];
            wrap_pulse_r <= next_wrap_s;
            at_max_r     <= (next_count_s == COUNT_MAX);
            at_min_r     <= (next_count_s == '0);
        end
    end

    assign count      = count_r;
    assign up_pulse   = up_pulse_r;
    assign dn_pulse   = dn_pulse_r;
    assign wrap_pulse = wrap_pulse_r;
    assign at_max     = at_max_r;
    assign at_min     = at_min_r;

endmodule

// File: tb/tb_btn_updown_counter.sv
// Bench for btn_updown_counter: three instances (wrap MOD=4, saturate MOD=4,
// wrap MOD=5/WIDTH=3) share the same buttons; expected events go through a queue.
module tb_btn_updown_counter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic btn_up = 1'b0;
    logic btn_dn = 1'b0;
    logic clr = 1'b0;

    logic [1:0] count0, count1;
    logic [2:0] count2;
    logic up0, dn0, wr0, mx0, mn0;
    logic up1, dn1, wr1, mx1, mn1;
    logic up2, dn2, wr2, mx2, mn2;

    always #5 clk = ~clk;

    btn_updown_counter #(.MOD(4), .WIDTH(2), .DB_CYCLES(4), .SATURATE(0)) u0 (
        .clk(clk), .rst(rst), .btn_up(btn_up), .btn_dn(btn_dn), .clr(clr),
        .count(count0), .up_pulse(up0), .dn_pulse(dn0), .wrap_pulse(wr0),
        .at_max(mx0), .at_min(mn0));

    btn_updown_counter #(.MOD(4), .WIDTH(2), .DB_CYCLES(4), .SATURATE(1)) u1 (
        .clk(clk), .rst(rst), .btn_up(btn_up), .btn_dn(btn_dn), .clr(clr),
        .count(count1), .up_pulse(up1), .dn_pulse(dn1), .wrap_pulse(wr1),
        .at_max(mx1), .at_min(mn1));

    btn_updown_counter #(.MOD(5), .WIDTH(3), .DB_CYCLES(4), .SATURATE(0)) u2 (
        .clk(clk), .rst(rst), .btn_up(btn_up), .btn_dn(btn_dn), .clr(clr),
        .count(count2), .up_pulse(up2), .dn_pulse(dn2), .wrap_pulse(wr2),
        .at_max(mx2), .at_min(mn2));

    typedef struct {
        logic up;
        logic dn;
        int   c0;
        int   c1;
        int   c2;
        logic w0;
        logic w2;
    } exp_t;

    exp_t sb_q[$];
    exp_t tbl[13];
    int   n_checks = 0;
    int   n_fail = 0;
    int   max2 = 0;

    task automatic chk(input string name, input integer act, input integer exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Scoreboard: every strobe must match the oldest queued expectation.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst && (up0 || dn0 || up1 || dn1 || up2 || dn2)) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_pulse", 1, 0);
            end else begin
                e = sb_q.pop_front();
                chk("up_pulse0", up0, e.up);
                chk("dn_pulse0", dn0, e.dn);
                chk("up_pulse1", up1, e.up);
                chk("dn_pulse2", dn2, e.dn);
                chk("count_wrap", count0, e.c0);
                chk("count_sat", count1, e.c1);
                chk("count_mod5", count2, e.c2);
                chk("wrap_pulse0", wr0, e.w0);
                chk("wrap_pulse1", wr1, 0);
                chk("wrap_pulse2", wr2, e.w2);
                chk("at_max0", mx0, (e.c0 == 3) ? 1 : 0);
                chk("at_min0", mn0, (e.c0 == 0) ? 1 : 0);
                chk("at_max2", mx2, (e.c2 == 4) ? 1 : 0);
            end
        end
    end

    always @(negedge clk) begin
        if (int'(count2) > max2) max2 = int'(count2);
    end

    task automatic press(input logic u, input logic d);
        @(negedge clk);
        btn_up = u;
        btn_dn = d;
        repeat (12) @(negedge clk);
        btn_up = 1'b0;
        btn_dn = 1'b0;
        repeat (10) @(negedge clk);
        chk("sb_drain", sb_q.size(), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_count0"}, count0, 0);
        chk({tag, "_count2"}, count2, 0);
        chk({tag, "_at_min"}, mn0, 1);
        chk({tag, "_at_max"}, mx0, 0);
        chk({tag, "_pulses"}, {up0, dn0, wr0}, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        // up, dn, count wrap4, count sat4, count wrap5, wrap4, wrap5 (all start at 0)
        tbl[0]  = '{1'b1, 1'b0, 1, 1, 1, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 1'b0, 2, 2, 2, 1'b0, 1'b0};
        tbl[2]  = '{1'b1, 1'b0, 3, 3, 3, 1'b0, 1'b0};
        tbl[3]  = '{1'b1, 1'b0, 0, 3, 4, 1'b1, 1'b0};
        tbl[4]  = '{1'b1, 1'b0, 1, 3, 0, 1'b0, 1'b1};
        tbl[5]  = '{1'b1, 1'b1, 1, 3, 0, 1'b0, 1'b0};
        tbl[6]  = '{1'b0, 1'b1, 0, 2, 4, 1'b0, 1'b1};
        tbl[7]  = '{1'b0, 1'b1, 3, 1, 3, 1'b1, 1'b0};
        tbl[8]  = '{1'b0, 1'b1, 2, 0, 2, 1'b0, 1'b0};
        tbl[9]  = '{1'b0, 1'b1, 1, 0, 1, 1'b0, 1'b0};
        tbl[10] = '{1'b0, 1'b1, 0, 0, 0, 1'b0, 1'b0};
        tbl[11] = '{1'b0, 1'b1, 3, 0, 4, 1'b1, 1'b1};
        tbl[12] = '{1'b1, 1'b0, 0, 1, 0, 1'b1, 1'b1};

        repeat (2) @(negedge clk);
        check_reset_outputs("por");
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // Latency: count and up_pulse move at edge 7 after the button rises.
        @(negedge clk);
        btn_up = 1'b1;
        sb_q.push_back('{1'b1, 1'b0, 1, 1, 1, 1'b0, 1'b0});
        repeat (6) @(negedge clk);
        chk("lat_edge6_count", count0, 0);
        chk("lat_edge6_pulse", up0, 0);
        @(negedge clk);
        chk("lat_edge7_count", count0, 1);
        chk("lat_edge7_pulse", up0, 1);
        @(negedge clk);
        chk("pulse_width", up0, 0);
        repeat (12) @(negedge clk);
        btn_up = 1'b0;
        repeat (10) @(negedge clk);
        chk("lat_drain", sb_q.size(), 0);

        // Bouncing button followed by a solid hold gives exactly one increment.
        sb_q.push_back('{1'b1, 1'b0, 2, 2, 2, 1'b0, 1'b0});
        for (int i = 0; i < 6; i++) begin
            btn_up = ~btn_up;
            repeat (2) @(negedge clk);
        end
        btn_up = 1'b1;
        repeat (20) @(negedge clk);
        btn_up = 1'b0;
        repeat (10) @(negedge clk);
        chk("bounce_drain", sb_q.size(), 0);
        chk("bounce_count", count0, 2);

        // Reset with debounce counter at 2 and the button still held.
        @(negedge clk);
        btn_up = 1'b1;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("mid_rst");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        sb_q.push_back('{1'b1, 1'b0, 1, 1, 1, 1'b0, 1'b0});
        repeat (6) @(negedge clk);
        chk("rst_edge6_count", count0, 0);
        @(negedge clk);
        chk("rst_edge7_count", count0, 1);
        repeat (10) @(negedge clk);
        btn_up = 1'b0;
        repeat (10) @(negedge clk);
        chk("rst_drain", sb_q.size(), 0);

        // Clear coincident with an accepted up event wins.
        @(negedge clk);
        btn_up = 1'b1;
        sb_q.push_back('{1'b1, 1'b0, 0, 0, 0, 1'b0, 1'b0});
        repeat (6) @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        chk("clr_count_sat", count1, 0);
        repeat (10) @(negedge clk);
        btn_up = 1'b0;
        repeat (10) @(negedge clk);
        chk("clr_drain", sb_q.size(), 0);

        do_reset();
        for (int i = 0; i < 13; i++) begin
            sb_q.push_back(tbl[i]);
            press(tbl[i].up, tbl[i].dn);
        end

        chk("mod5_range", (max2 <= 4) ? 1 : 0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
